// File: rtl/uart_tx_selector.sv
// uart_tx_selector
//   Glitch-free 2:1 selector for the board UART TX pin. Source 0 is the CPU UART, source 1 the
//   LiteDRAM debug UART. The slide switch is synchronised and debounced. The selection only
//   moves when both TX lines have been idle (high) for a full frame, so no byte in flight on
//   either source is ever cut off.
//
// Ports
//   i_clk      clock; all logic lives in this domain
//   i_rst      synchronous, active-high reset
//   i_sel_sw   raw slide switch, asynchronous (0 = CPU, 1 = LiteDRAM)
//   i_tx0      CPU UART TX, asynchronous
//   i_tx1      LiteDRAM UART TX, asynchronous
//   o_tx       registered UART TX pin
//   o_sel      source currently driving o_tx
//   o_pending  high while a requested switch waits for both lines to go idle
module uart_tx_selector #(
  parameter int unsigned CLK_FREQ_HZ     = 50000000,
  parameter int unsigned BAUD            = 115200,
  parameter int unsigned IDLE_BITS       = 11,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sel_sw,
  input  logic i_tx0,
  input  logic i_tx1,
  output logic o_tx,
  output logic o_sel,
  output logic o_pending
);

  localparam int unsigned IdleCycles = IDLE_BITS * CLK_FREQ_HZ / BAUD;
  localparam int unsigned IdleW      = $clog2(IdleCycles + 1);
  localparam int unsigned DebW       = $clog2(DEBOUNCE_CYCLES);

  localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleCycles);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {StActive, StWait} state_e;

  // Two-flop synchronisers; bit [1] is the synchronised value.
  logic [1:0] sw_sync_q, sw_sync_d;
  logic [1:0] tx0_sync_q, tx0_sync_d;
  logic [1:0] tx1_sync_q, tx1_sync_d;

  logic            req_q, req_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  logic [IdleW-1:0] idle0_cnt_q, idle0_cnt_d;
  logic [IdleW-1:0] idle1_cnt_q, idle1_cnt_d;

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   tx_q, tx_d;

  logic sw_s, tx0_s, tx1_s;
  logic idle0, idle1;

  always_comb begin
    sw_s  = sw_sync_q[1];
    tx0_s = tx0_sync_q[1];
    tx1_s = tx1_sync_q[1];

    sw_sync_d  = {sw_sync_q[0], i_sel_sw};
    tx0_sync_d = {tx0_sync_q[0], i_tx0};
    tx1_sync_d = {tx1_sync_q[0], i_tx1};

    // Debounce: the request only follows the switch after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; one agreeing sample restarts the count.
    req_d     = req_q;
    deb_cnt_d = deb_cnt_q;
    if (sw_s == req_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebMax) begin
      req_d     = sw_s;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    // Idle counters saturate so a long-idle line stays idle.
    idle0_cnt_d = idle0_cnt_q;
    if (!tx0_s) begin
      idle0_cnt_d = '0;
    end else if (idle0_cnt_q != IdleMax) begin
      idle0_cnt_d = idle0_cnt_q + 1'b1;
    end

    idle1_cnt_d = idle1_cnt_q;
    if (!tx1_s) begin
      idle1_cnt_d = '0;
    end else if (idle1_cnt_q != IdleMax) begin
      idle1_cnt_d = idle1_cnt_q + 1'b1;
    end

    idle0 = (idle0_cnt_q == IdleMax);
    idle1 = (idle1_cnt_q == IdleMax);

    // A switch flipped back while waiting cancels the request before any idle check.
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StActive: begin
        if (req_q != sel_q) state_d = StWait;
      end
      StWait: begin
        if (req_q == sel_q) begin
          state_d = StActive;
        end else if (idle0 && idle1) begin
          sel_d   = req_q;
          state_d = StActive;
        end
      end
    endcase

    // Uses the old selection, so on a switch o_tx changes source one cycle after o_sel.
    tx_d = sel_q ? tx1_s : tx0_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_sync_q   <= 2'b00;
      tx0_sync_q  <= 2'b11;
      tx1_sync_q  <= 2'b11;
      req_q       <= 1'b0;
      deb_cnt_q   <= '0;
      idle0_cnt_q <= '0;
      idle1_cnt_q <= '0;
      state_q     <= StActive;
      sel_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      sw_sync_q   <= sw_sync_d;
      tx0_sync_q  <= tx0_sync_d;
      tx1_sync_q  <= tx1_sync_d;
      req_q       <= req_d;
      deb_cnt_q   <= deb_cnt_d;
      idle0_cnt_q <= idle0_cnt_d;
      idle1_cnt_q <= idle1_cnt_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      tx_q        <= tx_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_sel     = sel_q;
  assign o_pending = (state_q == StWait);

endmodule
